// File: rtl/operand_fetch.sv
// Fetches an A/B operand pair through one synchronous RAM read port and pulses valid.
// Optional: define OPFETCH_SAME_ADDR_EN to issue a single read when both addresses match.
module operand_fetch #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int RAM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] addrA,
    input  logic [AW-1:0] addrB,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rden,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] dataA,
    output logic [DW-1:0] dataB,
    output logic          valid
);

`ifdef OPFETCH_SAME_ADDR_EN
    localparam bit SAME_ADDR_EN = 1'b1;
`else
    localparam bit SAME_ADDR_EN = 1'b0;
`endif

    // Two bits cover the legal read latency range of 1..3.
    localparam int CW = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        WAIT_A = 3'd2,
        RD_B   = 3'd3,
        WAIT_B = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e        state_q;
    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [AW-1:0] ram_addr_q;
    logic          ram_rden_q;
    logic [DW-1:0] data_a_q;
    logic [DW-1:0] data_b_q;
    logic          valid_q;
    logic          same_addr;

    assign same_addr = SAME_ADDR_EN && (addr_a_q == addr_b_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ram_addr_q <= '0;
            ram_rden_q <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; later non-blocking writes in the case arms win.
            ram_rden_q <= 1'b0;
            ram_addr_q <= '0;
            valid_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_a_q   <= addrA;
                        addr_b_q   <= addrB;
                        ram_addr_q <= addrA;
                        ram_rden_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= RD_A;
                    end
                end
                RD_A: begin
                    cnt_q   <= CW'(RAM_LAT);
                    state_q <= WAIT_A;
                end
                WAIT_A: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        data_a_q <= ram_q;
                        if (same_addr) begin
                            data_b_q <= ram_q;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            ram_addr_q <= addr_b_q;
                            ram_rden_q <= 1'b1;
                            state_q    <= RD_B;
                        end
                    end
                end
                RD_B: begin
                    cnt_q   <= CW'(RAM_LAT);
                    state_q <= WAIT_B;
                end
                WAIT_B: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        data_b_q <= ram_q;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign ram_addr = ram_addr_q;
    assign ram_rden = ram_rden_q;
    assign dataA    = data_a_q;
    assign dataB    = data_b_q;
    assign valid    = valid_q;

endmodule
